// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_queue_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction memory request/response bus between the prefetcher and imem.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  logic               imem_req;
  logic [XLEN-1:0]    imem_addr;
  logic               imem_ready;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );

endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Synchronous FIFO with flush; head is read straight from the storage flops.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Sequential instruction prefetcher feeding the F/D register; flushes on redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h00000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               set_PC,
  input  logic [XLEN-1:0]    new_PC,
  input  logic               stall_F_D,
  fetch_queue_if.master      imem,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [XLEN-1:0]    PC_out
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]    req_pc_q, req_pc_d;
  logic               in_flight_q, in_flight_d;
  logic [CW-1:0]      fifo_count;
  logic [CW:0]        reserved;
  logic [ENTRY_W-1:0] head_bits;
  fetch_entry_t       head, push_entry;
  logic               accept, push, pop;

  // Slots already filled plus the one outstanding response; never overcommit.
  assign reserved = {1'b0, fifo_count} + (CW+1)'(in_flight_q);

  always_comb begin
    imem.imem_req  = !reset && !set_PC && (reserved < (CW+1)'(DEPTH));
    imem.imem_addr = fetch_pc_q;
    accept         = imem.imem_req && imem.imem_ready;
    push           = imem.imem_rvalid && in_flight_q && !set_PC;
    instr_valid    = (fifo_count != '0);
    pop            = instr_valid && !stall_F_D && !set_PC;
  end

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    in_flight_d = accept;
    if (set_PC) begin
      fetch_pc_d  = word_align(new_PC);
      in_flight_d = 1'b0;
    end else if (accept) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
      req_pc_d   = fetch_pc_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= '0;
      in_flight_q <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      in_flight_q <= in_flight_d;
    end
  end

  assign push_entry = '{pc: req_pc_q, instr: imem.imem_rdata};

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .flush_i (set_PC),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .head_o  (head_bits),
    .count_o (fifo_count)
  );

  assign head      = fetch_entry_t'(head_bits);
  assign instr_out = instr_valid ? head.instr : NOP_INSTR;
  assign PC_out    = instr_valid ? head.pc : '0;

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction prefetch buffer between the instruction memory and the F/D pipeline register of the pipelined RV32 core.
- Issues sequential word fetches ahead of decode and buffers up to DEPTH {PC, instr} pairs.
- Presents the oldest pair to the F/D stage, holds it while decode stalls, and discards everything on a PC redirect from execute.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
- clock  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- set_PC  in  1  redirect request from execute.
- new_PC  in  32  redirect target; bits [1:0] are ignored and forced to zero.
- stall_F_D  in  1  decode cannot accept an instruction this cycle.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address, word aligned.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  response data valid; exactly 1 cycle after acceptance.
- imem_rdata  in  32  fetched instruction word.
- instr_valid  out  1  head entry is valid.
- instr_out  out  32  head instruction, or 32'h00000013 (NOP) when the queue is empty.
- PC_out  out  32  PC of the head entry; 0 when the queue is empty.

Behaviour:
- Reset: all outputs and state take these values at the clock edge where reset is high.
  - fetch_pc = RESET_PC; count = 0; in_flight = 0.
  - imem_req = 0 while reset is high; instr_valid = 0; instr_out = NOP; PC_out = 0.
  - A response arriving in the cycle after reset is dropped because in_flight = 0.
- Request:
  - imem_req = !reset && !set_PC && (count + in_flight < DEPTH); imem_addr = fetch_pc.
  - Acceptance = imem_req && imem_ready.
  - On acceptance: fetch_pc += 4 (wraps modulo 2^32); in_flight <= 1; the issued address is recorded.
  - On no acceptance: in_flight <= 0.
- Response: when imem_rvalid && in_flight, push {recorded address, imem_rdata}. imem_rvalid without in_flight is ignored.
- Pop: at the edge where instr_valid && !stall_F_D. Push and pop in the same cycle leave count unchanged.
- Output:
  - instr_valid = (count != 0).
  - instr_out and PC_out come from head registers, so there is no combinational path from imem_rdata.
  - A pushed word becomes visible the cycle after its response.
- Latency: redirect sampled at edge E0 → request for new_PC issued in the cycle after E0 → data written at E2 → instr_valid = 1 after E2 (2 edges). Steady-state throughput is 1 instruction/cycle.
- Redirect (set_PC high at an edge):
  - count <= 0; in_flight <= 0; fetch_pc <= {new_PC[31:2], 2'b00}.
  - No request is issued in that cycle.
  - The response in that cycle, or arriving in the next cycle, is discarded.
- Simultaneous events:
  - set_PC overrides stall_F_D, push and pop.
  - reset overrides set_PC.
- Full: the reservation rule (count + in_flight < DEPTH) guarantees a push never overflows. With the queue full and stall_F_D held, imem_req stays low and contents are unchanged.
- Empty: with stall_F_D low, NOP is presented with instr_valid = 0. Decode treats it as a bubble.
- imem_ready low: the request is held stable (same address) until accepted or a redirect occurs.

Decomposition:
- Shared package holds:
  - NOP_INSTR = 32'h00000013.
  - Width constants XLEN = 32 and INSTR_W = 32.
  - A fetch_entry_t typedef {pc[31:0], instr[31:0]}.
- One sub-module: sync_fifo.
  - Parameterised WIDTH and DEPTH.
  - Synchronous reset, flush input, push/pop, count output, registered head.
  - fetch_queue instantiates it with WIDTH = 64.

Test Plan:
- Reset then free-running imem (ready = 1) with a word memory of addr+0x100 → instr_valid after 2 edges, PC_out 0,4,8,... with instr_out 0x100,0x104,... one per cycle.
- Hold stall_F_D = 1 from the first valid cycle → count saturates at DEPTH = 4, imem_req drops low, and head stays PC 0 / 0x100. Release → PCs 0,4,8,12,16 are delivered in order with no gap or duplicate.
- set_PC = 1, new_PC = 0x203 while a request is in flight → the in-flight word is dropped, and 2 edges later PC_out = 0x200, followed by 0x204. No stale PC ever appears.
- imem_ready toggles 1,0,0,1 → imem_addr stays constant while ready is low, and the delivered PC sequence remains strictly +4.
- fetch_pc = 0xFFFFFFFC (via redirect) → the next request address is 0x00000000.
- Assert reset for 1 cycle mid-stream with imem_rvalid = 1 the following cycle → queue empty, instr_out = NOP, the response is ignored, and the first delivered PC is RESET_PC.
